// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR sequencer slice.
//   - op_e      : command opcodes carried on cmd_op
//   - state_e   : sequencer FSM states
//   - LfsrDefTaps / LfsrDefSeed : default tap mask and seed
//   - CntWidth  : width of the step counter (holds 1..256)
//   - lfsr_step : raw Fibonacci step, before zero-lockup substitution
package lfsr_pkg;

    typedef enum logic [1:0] {
        OpSeed = 2'd0,
        OpTaps = 2'd1,
        OpRun  = 2'd2,
        OpNop  = 2'd3
    } op_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam logic [7:0]  LfsrDefTaps = 8'h8C;
    localparam logic [7:0]  LfsrDefSeed = 8'h01;
    localparam int unsigned CntWidth    = 9;

    // Shift left, new LSB is the parity of the tapped bits.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] taps);
        return {s[6:0], ^(s & taps)};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: LFSR state and tap-mask registers with zero-lockup protection.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   seed_load, seed_val  load a new LFSR state (zero is replaced by DEF_SEED)
//   taps_load, taps_val  load a new tap mask (zero is replaced by DEF_TAPS)
//   step                 advance the LFSR by one step this edge
//   next_val             value the LFSR will hold after a step (combinational)
//   lock_err             sticky: a zero state was loaded or generated
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter logic [7:0] DEF_TAPS = LfsrDefTaps,
    parameter logic [7:0] DEF_SEED = LfsrDefSeed
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       seed_load,
    input  logic [7:0] seed_val,
    input  logic       taps_load,
    input  logic [7:0] taps_val,
    input  logic       step,
    output logic [7:0] next_val,
    output logic       lock_err
);

    logic [7:0] lfsr_q;
    logic [7:0] taps_q;
    logic       lock_q;
    logic [7:0] step_raw;
    logic       step_zero;

    always_comb begin
        step_raw  = lfsr_step(lfsr_q, taps_q);
        step_zero = (step_raw == 8'h00);
        next_val  = step_zero ? DEF_SEED : step_raw;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= DEF_SEED;
            taps_q <= DEF_TAPS;
            lock_q <= 1'b0;
        end else begin
            // Seed and step are mutually exclusive: seeds only arrive in IDLE.
            if (seed_load) begin
                if (seed_val == 8'h00) begin
                    lfsr_q <= DEF_SEED;
                    lock_q <= 1'b1;
                end else begin
                    lfsr_q <= seed_val;
                    lock_q <= 1'b0;
                end
            end else if (step) begin
                lfsr_q <= next_val;
                if (step_zero) begin
                    lock_q <= 1'b1;
                end
            end
            if (taps_load) begin
                taps_q <= (taps_val == 8'h00) ? DEF_TAPS : taps_val;
            end
        end
    end

    assign lock_err = lock_q;

endmodule

// File: rtl/lfsr_sequencer.sv
// lfsr_sequencer: command-driven LFSR stepper with a valid/ready output stage.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_op, cmd_arg             opcode (SEED/TAPS/RUN/NOP) and its argument
//   abort                       ends an active RUN without a further step
//   out_valid/out_ready         output handshake; out_data is the post-step LFSR value
//   busy                        high while a RUN is active
//   done                        one-cycle pulse with the final step of a RUN
//   lock_err                    sticky zero-lockup flag from the core
module lfsr_sequencer
    import lfsr_pkg::*;
#(
    parameter logic [7:0] DEF_TAPS = LfsrDefTaps,
    parameter logic [7:0] DEF_SEED = LfsrDefSeed
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_arg,
    input  logic       abort,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       done,
    output logic       lock_err
);

    state_e                state_q;
    logic [CntWidth-1:0]   remaining_q;
    logic                  out_valid_q;
    logic [7:0]            out_data_q;
    logic                  done_q;

    op_e        op;
    logic       accept;
    logic       step_en;
    logic [7:0] next_val;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign accept    = cmd_valid && cmd_ready;
    // Step only when the output slot is free or being drained; abort always wins.
    assign step_en   = (state_q == StRun) && (!out_valid_q || out_ready) && !abort;

    lfsr_core #(
        .DEF_TAPS (DEF_TAPS),
        .DEF_SEED (DEF_SEED)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (accept && (op == OpSeed)),
        .seed_val  (cmd_arg),
        .taps_load (accept && (op == OpTaps)),
        .taps_val  (cmd_arg),
        .step      (step_en),
        .next_val  (next_val),
        .lock_err  (lock_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Output stage runs in both states so a final value drains after RUN ends.
            if (step_en) begin
                out_data_q  <= next_val;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (accept && (op == OpRun)) begin
                        // An argument of zero requests the full 256 steps.
                        remaining_q <= (cmd_arg == 8'h00) ? CntWidth'(256)
                                                          : {1'b0, cmd_arg};
                        state_q     <= StRun;
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (step_en) begin
                        remaining_q <= remaining_q - CntWidth'(1);
                        if (remaining_q == CntWidth'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_lfsr_sequencer.sv
// tb_lfsr_sequencer: directed and randomized checks of lfsr_sequencer against a
// behavioural model that tracks the LFSR value, tap mask and lock flag.
module tb_lfsr_sequencer;
    import lfsr_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd3;
    logic [7:0] cmd_arg = 8'h00;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;
    logic       cmd_ready, out_valid, busy, done, lock_err;
    logic [7:0] out_data;

    int errors = 0;
    int checks = 0;

    // Model state.
    logic [7:0] m_lfsr = 8'h01;
    logic [7:0] m_taps = 8'h8C;
    logic       m_lock = 1'b0;
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    lfsr_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .lock_err  (lock_err)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: next value = state doubled mod 256 plus parity of tapped bits.
    task automatic m_advance();
        int v;
        v = ((int'(m_lfsr) * 2) % 256) + ($countones(m_lfsr & m_taps) % 2);
        if (v == 0) begin
            m_lfsr = 8'h01;
            m_lock = 1'b1;
        end else begin
            m_lfsr = v[7:0];
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'd3;
        if (op == 2'd0) begin
            if (arg == 8'h00) begin
                m_lfsr = 8'h01;
                m_lock = 1'b1;
            end else begin
                m_lfsr = arg;
                m_lock = 1'b0;
            end
        end else if (op == 2'd1) begin
            m_taps = (arg == 8'h00) ? 8'h8C : arg;
        end
    endtask

    // Issue a RUN and drain it. rdy_pct: chance of out_ready per cycle;
    // stall: cycles of out_ready low once the first output shows up;
    // abort_after: abort once this many transfers are done (0 = never).
    task automatic do_run(input logic [7:0] arg, input int rdy_pct, input int stall,
                          input int abort_after);
        int   total = (arg == 8'h00) ? 256 : int'(arg);
        int   xfers = 0;
        int   dones = 0;
        int   cyc = 0;
        int   first_v = -1;
        int   stall_left = 0;
        bit   stall_used = 0;
        bit   aborted = 0;
        bit   hold_p = 0;
        bit   did_abort;
        logic [7:0] hold_d = 8'h00;
        got_q.delete();
        send_cmd(2'd2, arg);
        cyc = 1;
        check("busy_after_run", busy, 1);
        while ((busy || out_valid) && cyc < 3000) begin
            if (hold_p) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_d);
            end
            if (out_valid && first_v < 0) begin
                first_v = cyc;
                if (!stall_used) begin
                    stall_left = stall;
                    stall_used = 1;
                end
            end
            if (done) begin
                dones++;
                check("done_busy_low", busy, 0);
                check("done_out_valid", out_valid, 1);
                check("done_prior_xfers", xfers, total - 1);
                if (rdy_pct == 100 && stall == 0) check("done_cycle", cyc, total + 1);
            end
            did_abort = 0;
            if (abort_after > 0 && !aborted && busy && xfers == abort_after) begin
                abort     = 1'b1;
                out_ready = 1'b0;
                aborted   = 1;
                did_abort = 1;
            end else if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(99) < rdy_pct);
            end
            hold_p = out_valid && !out_ready;
            hold_d = out_data;
            if (out_valid && out_ready) begin
                m_advance();
                check("xfer_data", out_data, m_lfsr);
                got_q.push_back(out_data);
                xfers++;
            end
            tick();
            cyc++;
            if (did_abort) begin
                abort = 1'b0;
                check("abort_busy_low", busy, 0);
                check("abort_cmd_ready", cmd_ready, 1);
                check("abort_pending_kept", out_valid, 1);
                check("abort_no_done", done, 0);
            end
        end
        out_ready = 1'b0;
        check("run_no_timeout", cyc < 3000, 1);
        check("xfer_count", xfers, aborted ? abort_after + 1 : total);
        check("done_pulses", dones, aborted ? 0 : 1);
        check("busy_low_after_run", busy, 0);
        if (rdy_pct == 100 && stall == 0 && !aborted) check("first_valid_cycle", first_v, 2);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_done", done, 0);
        check("rst_lock_err", lock_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        check("rst_cmd_ready", cmd_ready, 1);

        // Four steps from reset with the default taps.
        do_run(8'd4, 100, 0, 0);
        check("seq4_len", got_q.size(), 4);
        check("seq4_v0", got_q[0], 8'h02);
        check("seq4_v1", got_q[1], 8'h04);
        check("seq4_v2", got_q[2], 8'h09);
        check("seq4_v3", got_q[3], 8'h13);
        tick();
        check("busy_low_next", busy, 0);

        // Zero seed substitutes the default and flags lockup; a real seed clears it.
        send_cmd(2'd0, 8'h00);
        check("lock_after_zero_seed", lock_err, 1);
        do_run(8'd1, 100, 0, 0);
        check("zero_seed_run", got_q[0], 8'h02);
        send_cmd(2'd0, 8'h05);
        check("lock_cleared", lock_err, 0);

        // Backpressure: five stalled cycles on the first output.
        send_cmd(2'd0, 8'h01);
        do_run(8'd3, 100, 5, 0);
        check("stall_v0", got_q[0], 8'h02);
        check("stall_v1", got_q[1], 8'h04);
        check("stall_v2", got_q[2], 8'h09);

        // Full 256-step run, then one more step to confirm where the LFSR sits.
        send_cmd(2'd0, 8'h01);
        do_run(8'd0, 100, 0, 0);
        do_run(8'd1, 100, 0, 0);

        // Abort after three transfers; the pending fourth still drains.
        send_cmd(2'd0, 8'h01);
        do_run(8'd10, 100, 0, 3);
        check("abort_len", got_q.size(), 4);

        // Abort while idle does nothing.
        abort = 1'b1;
        send_cmd(2'd3, 8'h00);
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        do_run(8'd2, 100, 0, 0);

        // Generated zero: taps without bit 7 from 0x80 shifts to zero.
        send_cmd(2'd1, 8'h0C);
        send_cmd(2'd0, 8'h80);
        check("lock_before_gen_zero", lock_err, 0);
        do_run(8'd2, 100, 0, 0);
        check("gen_zero_sub", got_q[0], 8'h01);
        check("gen_zero_lock", lock_err, m_lock);

        // Randomized seeds, taps, lengths and backpressure.
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(3) != 0) send_cmd(2'd1, 8'($urandom_range(255)));
            if ($urandom_range(2) != 0) send_cmd(2'd0, 8'($urandom_range(255)));
            do_run(8'($urandom_range(1, 20)), $urandom_range(30, 100), $urandom_range(0, 3), 0);
            check("rand_lock", lock_err, m_lock);
        end

        // Reset in the middle of a stalled RUN.
        send_cmd(2'd1, 8'hB8);
        send_cmd(2'd0, 8'h37);
        send_cmd(2'd2, 8'd8);
        out_ready = 1'b0;
        repeat (3) tick();
        check("midrun_valid", out_valid, 1);
        check("midrun_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        check("midrun_rst_valid", out_valid, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_done", done, 0);
        check("midrun_rst_data", out_data, 8'h00);
        rst_n = 1'b1;
        m_lfsr = 8'h01;
        m_taps = 8'h8C;
        m_lock = 1'b0;
        tick();
        check("midrun_rst_ready", cmd_ready, 1);
        check("midrun_rst_no_done", done, 0);
        do_run(8'd1, 100, 0, 0);
        check("post_rst_first", got_q[0], 8'h02);

        // Zero tap mask restores the default mask.
        send_cmd(2'd1, 8'hB8);
        send_cmd(2'd1, 8'h00);
        send_cmd(2'd0, 8'h01);
        do_run(8'd4, 100, 0, 0);
        check("zero_taps_v3", got_q[3], 8'h13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
